// File: rtl/kernel_sched_pkg.sv
// rtl/kernel_sched_pkg.sv - shared state encoding, kernel count and burst sizing
package kernel_sched_pkg;

  localparam int NUM_KERNELS = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ADDR   = 2'd2,
    ST_DATA   = 2'd3
  } sched_state_t;

  function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                  input int unsigned data_w);
    return burst_len * data_w / 8;
  endfunction

endpackage

// File: rtl/kernel_addr_tracker.sv
// rtl/kernel_addr_tracker.sv - one kernel fetch pointer with end-of-region wrap/done handling
module kernel_addr_tracker
  import kernel_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BYTES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clr_done,
  input  logic              i_advance,
  input  logic              i_wrap_en,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_done;
  logic [ADDR_W-1:0] w_nxt;
  logic              w_past_end;

  // The sum wraps modulo 2^ADDR_W, so a region ending at the top of memory restarts at 0.
  assign w_nxt      = r_ptr + ADDR_W'(BYTES);
  assign w_past_end = w_nxt > i_end_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
    end else begin
      if (i_load) begin
        r_ptr <= i_start_addr;
      end else if (i_advance) begin
        if (!w_past_end) begin
          r_ptr <= w_nxt;
        end else if (i_wrap_en) begin
          r_ptr <= i_start_addr;
        end
      end

      if (i_load || i_clr_done) begin
        r_done <= 1'b0;
      end else if (i_advance && w_past_end && !i_wrap_en) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_done = r_done;

endmodule

// File: rtl/kernel_fetch_scheduler.sv
// rtl/kernel_fetch_scheduler.sv - round-robin AXI burst reader feeding three kernel FIFOs
module kernel_fetch_scheduler
  import kernel_sched_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_BURST_LEN  = 8,
  parameter int FIFO_DEPTH         = 128
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [NUM_KERNELS-1:0]                    skip_en,
  input  logic [NUM_KERNELS-1:0]                    wrap_en,
  input  logic [NUM_KERNELS*C_S_AXI_ADDR_WIDTH-1:0] kernel_start_addr,
  input  logic [NUM_KERNELS*C_S_AXI_ADDR_WIDTH-1:0] kernel_end_addr,
  input  logic [NUM_KERNELS*8-1:0]                  fifo_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             fifo_wr_data,
  output logic [NUM_KERNELS-1:0]                    fifo_wr_en,
  output logic [NUM_KERNELS-1:0]                    kernel_done,
  output logic                                      busy,
  output logic                                      rd_error,
  output logic [C_S_AXI_ID_WIDTH-1:0]               M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]             M_axi_araddr,
  output logic                                      M_axi_arvalid,
  output logic [7:0]                                M_axi_arlen,
  output logic [2:0]                                M_axi_arsize,
  output logic [1:0]                                M_axi_arburst,
  output logic [3:0]                                M_axi_arcache,
  input  logic                                      M_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]               M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             M_axi_rdata,
  input  logic [1:0]                                M_axi_rresp,
  input  logic                                      M_axi_rlast,
  input  logic                                      M_axi_rvalid,
  output logic                                      M_axi_rready
);

  localparam int          AW         = C_S_AXI_ADDR_WIDTH;
  localparam int          BYTES      = bytes_per_burst(C_S_AXI_BURST_LEN, C_S_AXI_DATA_WIDTH);
  localparam logic [8:0]  ELIG_LIMIT = 9'(FIFO_DEPTH - C_S_AXI_BURST_LEN);
  localparam logic [1:0]  LAST_KERN  = 2'(NUM_KERNELS - 1);

  sched_state_t                  r_state;
  sched_state_t                  w_state_nxt;
  logic [1:0]                    r_grant;
  logic [1:0]                    r_last_grant;
  logic                          r_flush;
  logic                          r_rd_error;
  logic [NUM_KERNELS-1:0]        r_wr_en;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wr_data;

  logic [NUM_KERNELS-1:0]        w_elig;
  logic [1:0]                    w_pick;
  logic [1:0]                    w_idx;
  logic                          w_pick_vld;
  logic                          w_ar_hs;
  logic                          w_beat;
  logic                          w_last;
  logic                          w_restart;
  logic                          w_reload;
  logic                          w_set_flush;
  logic [AW-1:0]                 w_ptr [NUM_KERNELS];
  logic                          w_unused_rid;

  assign w_unused_rid = ^M_axi_rid;

  // Occupancy is widened to 9 bits so the headroom test never underflows.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      w_elig[i] = !skip_en[i] && !kernel_done[i] &&
                  ({1'b0, fifo_count[8*i +: 8]} <= ELIG_LIMIT);
    end
  end

  always_comb begin
    w_pick     = r_last_grant;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= NUM_KERNELS; k++) begin
      w_idx = 2'((int'(r_last_grant) + k) % NUM_KERNELS);
      if (!w_pick_vld && w_elig[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_ar_hs  = (r_state == ST_ADDR) && M_axi_arready;
  assign w_beat   = (r_state == ST_DATA) && M_axi_rvalid;
  assign w_last   = w_beat && M_axi_rlast;

  // A start that lands while a burst is in flight is deferred until that burst drains.
  assign w_restart   = start && ((r_state == ST_IDLE) || (r_state == ST_SELECT) ||
                                 ((r_state == ST_DATA) && w_last));
  assign w_set_flush = start && ((r_state == ST_ADDR) || ((r_state == ST_DATA) && !w_last));
  assign w_reload    = w_restart || (w_last && r_flush);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SELECT;
      ST_SELECT: if (!start && w_pick_vld) w_state_nxt = ST_ADDR;
      ST_ADDR:   if (M_axi_arready) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_last) w_state_nxt = ST_SELECT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_KERN;
      r_flush      <= 1'b0;
      r_rd_error   <= 1'b0;
      r_wr_en      <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_SELECT) && (w_state_nxt == ST_ADDR)) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end else if (w_reload) begin
        r_last_grant <= LAST_KERN;
      end

      if (w_set_flush) begin
        r_flush <= 1'b1;
      end else if (w_last) begin
        r_flush <= 1'b0;
      end

      if (start) begin
        r_rd_error <= 1'b0;
      end else if (w_beat && (M_axi_rresp != 2'b00)) begin
        r_rd_error <= 1'b1;
      end

      r_wr_en <= (w_beat && !r_flush) ? (NUM_KERNELS'(1) << r_grant) : '0;
      if (w_beat) begin
        r_wr_data <= M_axi_rdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_KERNELS; g++) begin : g_trk
    kernel_addr_tracker #(
      .ADDR_W (AW),
      .BYTES  (BYTES)
    ) u_trk (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_reload),
      .i_clr_done   (start),
      .i_advance    (w_ar_hs && (r_grant == 2'(g))),
      .i_wrap_en    (wrap_en[g]),
      .i_start_addr (kernel_start_addr[g*AW +: AW]),
      .i_end_addr   (kernel_end_addr[g*AW +: AW]),
      .o_ptr        (w_ptr[g]),
      .o_done       (kernel_done[g])
    );
  end

  assign fifo_wr_data  = r_wr_data;
  assign fifo_wr_en    = r_wr_en;
  assign rd_error      = r_rd_error;
  assign busy          = (r_state != ST_IDLE);
  assign M_axi_arvalid = (r_state == ST_ADDR);
  assign M_axi_rready  = (r_state == ST_DATA);
  assign M_axi_araddr  = w_ptr[r_grant];
  assign M_axi_arid    = C_S_AXI_ID_WIDTH'(1);
  assign M_axi_arlen   = 8'(C_S_AXI_BURST_LEN - 1);
  assign M_axi_arsize  = 3'($clog2(C_S_AXI_DATA_WIDTH / 8));
  assign M_axi_arburst = 2'b01;
  assign M_axi_arcache = 4'b0011;

endmodule

// File: tb/tb_kernel_fetch_scheduler.sv
// tb/tb_kernel_fetch_scheduler.sv - scoreboard bench for the kernel fetch scheduler
module tb_kernel_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  skip_en;
  logic [2:0]  wrap_en;
  logic [95:0] kernel_start_addr;
  logic [95:0] kernel_end_addr;
  logic [23:0] fifo_count;
  logic [63:0] fifo_wr_data;
  logic [2:0]  fifo_wr_en;
  logic [2:0]  kernel_done;
  logic        busy;
  logic        rd_error;
  logic [2:0]  M_axi_arid;
  logic [31:0] M_axi_araddr;
  logic        M_axi_arvalid;
  logic [7:0]  M_axi_arlen;
  logic [2:0]  M_axi_arsize;
  logic [1:0]  M_axi_arburst;
  logic [3:0]  M_axi_arcache;
  logic        M_axi_arready;
  logic [2:0]  M_axi_rid;
  logic [63:0] M_axi_rdata;
  logic [1:0]  M_axi_rresp;
  logic        M_axi_rlast;
  logic        M_axi_rvalid;
  logic        M_axi_rready;

  always #5 clk = ~clk;

  kernel_fetch_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .skip_en           (skip_en),
    .wrap_en           (wrap_en),
    .kernel_start_addr (kernel_start_addr),
    .kernel_end_addr   (kernel_end_addr),
    .fifo_count        (fifo_count),
    .fifo_wr_data      (fifo_wr_data),
    .fifo_wr_en        (fifo_wr_en),
    .kernel_done       (kernel_done),
    .busy              (busy),
    .rd_error          (rd_error),
    .M_axi_arid        (M_axi_arid),
    .M_axi_araddr      (M_axi_araddr),
    .M_axi_arvalid     (M_axi_arvalid),
    .M_axi_arlen       (M_axi_arlen),
    .M_axi_arsize      (M_axi_arsize),
    .M_axi_arburst     (M_axi_arburst),
    .M_axi_arcache     (M_axi_arcache),
    .M_axi_arready     (M_axi_arready),
    .M_axi_rid         (M_axi_rid),
    .M_axi_rdata       (M_axi_rdata),
    .M_axi_rresp       (M_axi_rresp),
    .M_axi_rlast       (M_axi_rlast),
    .M_axi_rvalid      (M_axi_rvalid),
    .M_axi_rready      (M_axi_rready)
  );

  int          checks = 0;
  int          errors = 0;
  int          ar_cnt = 0;
  logic [31:0] exp_ar [$];
  logic [66:0] exp_wr [$];

  logic [31:0] s_addr;
  int          s_beat;
  logic        err_en;
  logic [31:0] err_addr;
  int          err_beat;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
    return {a, 32'hD000_0000 | 32'(b)};
  endfunction

  // Memory slave: accepts every address at once, then returns 8 beats back to back.
  initial begin : slave
    logic        hs;
    logic        bt;
    logic [31:0] a;
    M_axi_arready = 1'b1;
    M_axi_rvalid  = 1'b0;
    M_axi_rlast   = 1'b0;
    M_axi_rresp   = 2'b00;
    M_axi_rdata   = '0;
    M_axi_rid     = 3'd1;
    s_addr        = '0;
    s_beat        = 0;
    forever begin
      @(negedge clk);
      hs = M_axi_arvalid && M_axi_arready;
      a  = M_axi_araddr;
      bt = M_axi_rvalid && M_axi_rready;
      @(posedge clk);
      #1;
      if (reset) begin
        M_axi_rvalid = 1'b0;
        M_axi_rlast  = 1'b0;
      end else begin
        if (bt) begin
          s_beat++;
          if (M_axi_rlast) M_axi_rvalid = 1'b0;
        end
        if (hs) begin
          s_addr       = a;
          s_beat       = 0;
          M_axi_rvalid = 1'b1;
        end
        M_axi_rlast = (s_beat == 7);
        M_axi_rdata = beat_data(s_addr, s_beat);
        M_axi_rresp = (err_en && s_addr == err_addr && s_beat == err_beat) ? 2'b10 : 2'b00;
      end
    end
  end

  initial begin : monitor
    logic [31:0] ea;
    logic [66:0] ew;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && M_axi_arvalid === 1'b1 && M_axi_arready) begin
        ar_cnt++;
        checks++;
        if (exp_ar.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected got araddr=%h required no request", M_axi_araddr);
        end else begin
          ea = exp_ar.pop_front();
          if (M_axi_araddr !== ea) begin
            errors++;
            $display("FAIL araddr got %h required %h", M_axi_araddr, ea);
          end
        end
      end
      if (reset === 1'b0 && fifo_wr_en !== 3'b000) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got en=%b data=%h required no write", fifo_wr_en, fifo_wr_data);
        end else begin
          ew = exp_wr.pop_front();
          if ({fifo_wr_en, fifo_wr_data} !== ew) begin
            errors++;
            $display("FAIL fifo_write got en=%b data=%h required en=%b data=%h",
                     fifo_wr_en, fifo_wr_data, ew[66:64], ew[63:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic exp_burst(input int k, input logic [31:0] addr, input int nwr);
    exp_ar.push_back(addr);
    for (int b = 0; b < nwr; b++) exp_wr.push_back({3'(1 << k), beat_data(addr, b)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    skip_en = 3'b111;
    wrap_en = 3'b000;
    fifo_count = '0;
    err_en = 1'b0;
    kernel_start_addr = {32'h2000, 32'h1000, 32'h0};
    kernel_end_addr = {3{32'hFFFF_0000}};
    repeat (2) @(negedge clk);
    exp_ar.delete();
    exp_wr.delete();
    ar_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ar(input string name, input int n);
    int t = 0;
    while (ar_cnt < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_ar_count"}, 64'(ar_cnt), 64'(n));
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_wr.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_wr_pending"}, 64'(exp_wr.size()), 64'd0);
    chk({name, "_ar_pending"}, 64'(exp_ar.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1;
    start = 1'b0;
    skip_en = 3'b111;
    wrap_en = 3'b000;
    fifo_count = '0;
    err_en = 1'b0;
    err_addr = '0;
    err_beat = 0;
    kernel_start_addr = '0;
    kernel_end_addr = '0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(M_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(M_axi_rready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_wr_data", fifo_wr_data, 64'd0);
    chk("rst_done", 64'(kernel_done), 64'd0);
    chk("rst_rd_error", 64'(rd_error), 64'd0);
    chk("const_ar", {M_axi_arid, M_axi_arlen, M_axi_arsize, M_axi_arburst, M_axi_arcache},
        {3'd1, 8'd7, 3'd3, 2'd1, 4'b0011});

    // Plain round robin over all three kernels.
    skip_en = 3'b000;
    exp_burst(0, 32'h0, 8);
    exp_burst(1, 32'h1000, 8);
    exp_burst(2, 32'h2000, 8);
    exp_burst(0, 32'h40, 8);
    pulse_start();
    wait_ar("rr", 4);
    skip_en = 3'b111;
    wait_drain("rr");
    chk("rr_busy", 64'(busy), 64'd1);

    // Kernel 1 skipped.
    do_reset();
    skip_en = 3'b010;
    exp_burst(0, 32'h0, 8);
    exp_burst(2, 32'h2000, 8);
    exp_burst(0, 32'h40, 8);
    exp_burst(2, 32'h2040, 8);
    pulse_start();
    wait_ar("skip", 4);
    skip_en = 3'b111;
    wait_drain("skip");

    // Wrap at end of a two-burst region.
    do_reset();
    skip_en = 3'b110;
    wrap_en = 3'b001;
    kernel_end_addr[31:0] = 32'h7F;
    exp_burst(0, 32'h0, 8);
    exp_burst(0, 32'h40, 8);
    exp_burst(0, 32'h0, 8);
    pulse_start();
    wait_ar("wrap", 3);
    skip_en = 3'b111;
    wait_drain("wrap");
    chk("wrap_done", 64'(kernel_done), 64'd0);

    // Same region without wrap: done after the second burst, nothing more requested.
    do_reset();
    skip_en = 3'b110;
    kernel_end_addr[31:0] = 32'h7F;
    exp_burst(0, 32'h0, 8);
    exp_burst(0, 32'h40, 8);
    pulse_start();
    wait_ar("nowrap", 2);
    wait_drain("nowrap");
    repeat (20) @(negedge clk);
    chk("nowrap_no_third", 64'(ar_cnt), 64'd2);
    chk("nowrap_done", 64'(kernel_done), 64'b001);

    // FIFO headroom threshold on kernel 2.
    do_reset();
    skip_en = 3'b011;
    fifo_count = {8'd121, 8'd0, 8'd0};
    exp_burst(2, 32'h2000, 8);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("full_held_off", 64'(ar_cnt), 64'd0);
    fifo_count[23:16] = 8'd120;
    wait_ar("full", 1);
    skip_en = 3'b111;
    wait_drain("full");

    // Restart on the third beat: rest of burst dropped, next fetch from reloaded kernel 0.
    do_reset();
    skip_en = 3'b000;
    exp_burst(0, 32'h0, 3);
    exp_burst(0, 32'h500, 8);
    pulse_start();
    kernel_start_addr[31:0] = 32'h500;
    begin : find_beat
      int t = 0;
      while (!(M_axi_rvalid && M_axi_rready && s_beat == 2) && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("flush_third_beat_seen", 64'(s_beat), 64'd2);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ar("flush", 2);
    skip_en = 3'b111;
    wait_drain("flush");

    // Error response: sticky, data still written, cleared by the next start.
    do_reset();
    skip_en = 3'b110;
    err_en = 1'b1;
    err_addr = 32'h0;
    err_beat = 4;
    exp_burst(0, 32'h0, 8);
    pulse_start();
    wait_ar("err", 1);
    skip_en = 3'b111;
    wait_drain("err");
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(rd_error), 64'd1);
    pulse_start();
    chk("err_cleared", 64'(rd_error), 64'd0);

    // Reset in the middle of a burst.
    do_reset();
    skip_en = 3'b000;
    err_en = 1'b1;
    err_addr = 32'h0;
    err_beat = 0;
    exp_burst(0, 32'h0, 8);
    pulse_start();
    wait_ar("midrst", 1);
    repeat (4) @(negedge clk);
    chk("midrst_err_before", 64'(rd_error), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rready", 64'(M_axi_rready), 64'd0);
    chk("midrst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("midrst_wr_data", fifo_wr_data, 64'd0);
    chk("midrst_rd_error", 64'(rd_error), 64'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_fetch_scheduler.md
KERNEL_FETCH_SCHEDULER -- requirements
Module: kernel_fetch_scheduler

Interface
REQ-001 C_S_AXI_ID_WIDTH, 3, AXI ID width.
REQ-002 C_S_AXI_ADDR_WIDTH, 32, AXI address width.
REQ-003 C_S_AXI_DATA_WIDTH, 64, AXI data width.
REQ-004 C_S_AXI_BURST_LEN, 8, beats per read burst.
REQ-005 FIFO_DEPTH, 128, depth of each kernel FIFO, in words.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse: load pointers and begin a new pass.
REQ-009 skip_en  in  3  bit i set excludes kernel i from arbitration.
REQ-010 wrap_en  in  3  bit i set restarts kernel i at its start address after its end address.
REQ-011 kernel_start_addr  in  96  three 32-bit start byte addresses; kernel i uses [32i+31:32i].
REQ-012 kernel_end_addr  in  96  three 32-bit inclusive end byte addresses.
REQ-013 fifo_count  in  24  three 8-bit occupancy counts of the kernel FIFOs.
REQ-014 fifo_wr_data  out  DATA_W  registered read data.
REQ-015 fifo_wr_en  out  3  one-hot write strobe, one bit per kernel FIFO.
REQ-016 kernel_done  out  3  bit i set when kernel i has reached its end with wrap disabled.
REQ-017 busy  out  1  high when the state is not IDLE.
REQ-018 rd_error  out  1  sticky flag for any non-OKAY rresp.
REQ-019 M_axi_arid/araddr/arvalid  out  ID_W/ADDR_W/1  read address channel.
REQ-020 M_axi_arlen/arsize/arburst/arcache  out  8/3/2/4  constants: BURST_LEN-1, log2(DATA_W/8), INCR (1), 4'b0011.
REQ-021 M_axi_arready  in  1  read address accept.
REQ-022 M_axi_rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  read data channel.
REQ-023 M_axi_rready  out  1  read data accept.

Function
REQ-024 The FSM SHALL have four states: IDLE, SELECT, ADDR and DATA; a start pulse moves IDLE to SELECT.
REQ-025 On start, ptr[i] SHALL load kernel_start_addr[i], kernel_done and rd_error SHALL clear, and the round-robin pointer SHALL reset so kernel 0 has highest priority.
REQ-026 Kernel i SHALL be eligible when skip_en[i]=0, kernel_done[i]=0 and fifo_count[i] <= FIFO_DEPTH-BURST_LEN; this comparison SHALL be evaluated at 9 bits so it cannot underflow.
REQ-027 In SELECT, the first eligible kernel after the last grant, in round-robin order, SHALL be granted and the FSM SHALL go to ADDR the next cycle; with no eligible kernel the FSM SHALL stay in SELECT.
REQ-028 In ADDR, M_axi_arvalid SHALL be 1 with M_axi_araddr=ptr[grant], and both SHALL stay stable until M_axi_arready; on the handshake the FSM SHALL go to DATA.
REQ-029 On the address handshake, with BYTES=BURST_LEN*DATA_W/8 and nxt=ptr+BYTES computed modulo 2^32:
  - if nxt > kernel_end_addr[i] and wrap_en[i]=1, ptr SHALL become start_addr;
  - if nxt > kernel_end_addr[i] and wrap_en[i]=0, ptr SHALL not change and kernel_done[i] SHALL set;
  - otherwise ptr SHALL become nxt.
REQ-030 At most one burst SHALL be outstanding; M_axi_rready SHALL be 1 only in DATA.
REQ-031 Each beat with rvalid&rready SHALL drive fifo_wr_data=rdata and fifo_wr_en[grant]=1 exactly one cycle later; at most one fifo_wr_en bit SHALL be high in any cycle.
REQ-032 A beat with rlast SHALL return the FSM to SELECT; the next grant SHALL be evaluated no earlier than the following cycle.
REQ-033 A beat with rresp != 0 SHALL set rd_error; its data SHALL still be written.
REQ-034 Start in SELECT SHALL reload the pointers and re-arbitrate from kernel 0.
REQ-035 Start in ADDR SHALL keep arvalid asserted until the handshake and SHALL set a flush flag.
REQ-036 Start in DATA SHALL set the flush flag.
REQ-037 While the flush flag is set, beats SHALL be accepted but not written; the flag SHALL clear on rlast, and the pointers SHALL reload at that time.
REQ-038 M_axi_arid SHALL be the constant 1.

Reset
REQ-039 When reset=1 at a clock edge, the following SHALL all be 0 the next cycle: state=IDLE, arvalid, rready, fifo_wr_en, fifo_wr_data, kernel_done, rd_error, busy, the pointers and the flush flag.
REQ-040 Reset SHALL override start, including in the middle of a burst; recovery of the AXI interconnect is the system's responsibility.

Structure
REQ-041 A shared package kernel_sched_pkg SHALL hold the state encoding, NUM_KERNELS=3 and the BYTES_PER_BURST function.
REQ-042 A sub-module kernel_addr_tracker SHALL hold one pointer with its wrap and done logic, and SHALL be instantiated three times.

Verification
REQ-043 start with all kernels eligible, start addresses 0x0/0x1000/0x2000, ends large, single-cycle arready -> araddr sequence 0x0, 0x1000, 0x2000, 0x40, and each burst raises 8 fifo_wr_en strobes on the granted kernel only.
REQ-044 skip_en=3'b010 -> kernel 1 is never granted; grants alternate 0, 2, 0, 2.
REQ-045 Kernel 0 with start=0x0, end=0x7F, wrap_en=1 -> araddr 0x0, 0x40, 0x0; with wrap_en=0 -> kernel_done[0]=1 after the second burst and no third request.
REQ-046 fifo_count[2]=121 with FIFO_DEPTH=128 -> kernel 2 is skipped until the count drops to 120, then granted.
REQ-047 start asserted on the third beat of a burst -> the remaining beats produce no fifo_wr_en, and the next araddr equals the reloaded start address of kernel 0.
REQ-048 rresp=2'b10 on one beat -> rd_error=1 until the next start, and the data is still written.
